interp_weights_seq: RTL and testbench

- Parametrised barycentric weight generator for the rasteriser.
- Takes the triangle area and three sub-triangle areas, all signed. Produces w_i = (area_i << FRAC_BITS) / area_012 as signed fixed-point values.
- Computes all three quotients with a true multi-cycle restoring divider. Three datapaths share one iteration counter.
- Uses valid/ready handshakes on input and output. Sits between the edge/area unit and the attribute interpolator.

---
 rtl/interp_weights_seq.sv | 157 +++++++++++++++
 tb/tb_interp_weights_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/interp_weights_seq.sv
// Barycentric weight generator: w_i = (area_i << FRAC_BITS) / area_012 via three lock-step restoring dividers.
// Latency: QW+2 cycles from accept to out_valid (2 for a zero divisor); one set in flight, outputs held until out_ready.
module interp_weights_seq #(
    parameter int AREA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AREA_W-1:0] area_012,
    input  logic [AREA_W-1:0] area_p12,
    input  logic [AREA_W-1:0] area_0p2,
    input  logic [AREA_W-1:0] area_01p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  w0,
    output logic [OUT_W-1:0]  w1,
    output logic [OUT_W-1:0]  w2,
    output logic              degenerate
);

    localparam int QW = AREA_W + FRAC_BITS;
    localparam int CW = $clog2(QW + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] SIGN  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    generate
        if (OUT_W < AREA_W + FRAC_BITS + 1) begin : g_width_check
            $error("interp_weights_seq: OUT_W must be >= AREA_W+FRAC_BITS+1");
        end
    endgenerate

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [AREA_W-1:0] div_r;
    logic [AREA_W-1:0] dvd_r   [3];
    logic [AREA_W:0]   div_mag;
    logic [AREA_W:0]   rem     [3];
    logic [QW-1:0]     dq      [3];
    logic [2:0]        sgn;
    logic              zero_div;

    logic [AREA_W:0]   shifted [3];
    logic [AREA_W+1:0] trial   [3];

    // Magnitude in AREA_W+1 bits so the most negative input is exact.
    function automatic logic [AREA_W:0] mag(input logic [AREA_W-1:0] a);
        logic [AREA_W:0] e;
        e = {a[AREA_W-1], a};
        return a[AREA_W-1] ? -e : e;
    endfunction

    function automatic logic [OUT_W-1:0] apply_sign(input logic s, input logic [QW-1:0] q);
        logic [OUT_W-1:0] e;
        e = OUT_W'(q);
        return s ? -e : e;
    endfunction

    function automatic logic [QW-1:0] scaled(input logic [AREA_W-1:0] a);
        logic [AREA_W:0] m;
        m = mag(a);
        return {m[AREA_W-1:0], {FRAC_BITS{1'b0}}};
    endfunction

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    // Shared remainder/quotient register: dividend bits shift out the top as quotient bits shift in.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            shifted[i] = {rem[i][AREA_W-1:0], dq[i][QW-1]};
            trial[i]   = {1'b0, shifted[i]} - {1'b0, div_mag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            w0         <= '0;
            w1         <= '0;
            w2         <= '0;
            degenerate <= 1'b0;
            zero_div   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div_r    <= area_012;
                        dvd_r[0] <= area_p12;
                        dvd_r[1] <= area_0p2;
                        dvd_r[2] <= area_01p;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    zero_div <= (div_r == '0);
                    div_mag  <= mag(div_r);
                    for (int i = 0; i < 3; i++) begin
                        rem[i] <= '0;
                        dq[i]  <= scaled(dvd_r[i]);
                        sgn[i] <= dvd_r[i][AREA_W-1] ^ div_r[AREA_W-1];
                    end
                    // A zero divisor skips the divider but still lands results through SIGN.
                    if (div_r == '0) begin
                        state <= SIGN;
                    end else begin
                        cnt   <= CW'(QW);
                        state <= DIV;
                    end
                end
                DIV: begin
                    for (int i = 0; i < 3; i++) begin
                        if (!trial[i][AREA_W+1]) begin
                            rem[i] <= trial[i][AREA_W:0];
                            dq[i]  <= {dq[i][QW-2:0], 1'b1};
                        end else begin
                            rem[i] <= shifted[i];
                            dq[i]  <= {dq[i][QW-2:0], 1'b0};
                        end
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    if (zero_div) begin
                        w0         <= '0;
                        w1         <= '0;
                        w2         <= '0;
                        degenerate <= 1'b1;
                    end else begin
                        w0         <= apply_sign(sgn[0], dq[0]);
                        w1         <= apply_sign(sgn[1], dq[1]);
                        w2         <= apply_sign(sgn[2], dq[2]);
                        degenerate <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interp_weights_seq.sv
// Directed bench for interp_weights_seq with hand-computed weights, latency, back-pressure and reset cases.
module tb_interp_weights_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] area_012, area_p12, area_0p2, area_01p;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] w0, w1, w2;
    logic        degenerate;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    interp_weights_seq #(.AREA_W(16), .FRAC_BITS(8), .OUT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .area_012(area_012), .area_p12(area_p12), .area_0p2(area_0p2), .area_01p(area_01p),
        .out_valid(out_valid), .out_ready(out_ready),
        .w0(w0), .w1(w1), .w2(w2), .degenerate(degenerate)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic scramble();
        area_012 = 16'($urandom);
        area_p12 = 16'($urandom);
        area_0p2 = 16'($urandom);
        area_01p = 16'($urandom);
    endtask

    task automatic send(input int a, input int b, input int c, input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        area_012 = 16'(a);
        area_p12 = 16'(b);
        area_0p2 = 16'(c);
        area_01p = 16'(d);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic txn(input string name, input int a, input int b, input int c, input int d,
                       input int e0, input int e1, input int e2, input int edeg, input int elat);
        int lat;
        out_ready = 1'b1;
        send(a, b, c, d);
        wait_valid(lat);
        chk({name, "_latency"}, 32'(lat), 32'(elat));
        chk({name, "_w0"}, w0, 32'(e0));
        chk({name, "_w1"}, w1, 32'(e1));
        chk({name, "_w2"}, w2, 32'(e2));
        chk({name, "_degenerate"}, 32'(degenerate), 32'(edeg));
        @(posedge clk);
        #1;
        chk({name, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
        chk({name, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        area_012  = '0;
        area_p12  = '0;
        area_0p2  = '0;
        area_01p  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready_low", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_w0", w0, 32'd0);
        chk("reset_degenerate", 32'(degenerate), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        txn("basic",   100,    25,    25,     50,     64,   64,  128, 0, 26);
        txn("trunc",     3,     1,    -1,      3,     85,  -85,  256, 0, 26);
        txn("negmax", -100,   -50,    50, -32768,    128, -128, 83886, 0, 26);
        txn("degen",     0,     5,     6,      7,      0,    0,    0, 1, 2);
        txn("outside",  10,   -30,     0,      7,   -768,    0,  179, 0, 26);
        txn("bigdiv", -32768, -32768, 16384,  1,    256, -128,    0, 0, 26);

        // Back-pressure: outputs frozen while out_ready is low.
        out_ready = 1'b0;
        send(100, 25, 25, 50);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd26);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            scramble();
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_w0", w0, 32'd64);
            chk("bp_w2", w2, 32'd128);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_out_valid_after_hs", 32'(out_valid), 32'd0);
        chk("bp_in_ready_after_hs", 32'(in_ready), 32'd1);

        // Reset in the middle of a division.
        send(3, 1, -1, 3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_w0", w0, 32'd0);
        chk("midrst_w2", w2, 32'd0);
        txn("after_rst", 100, 25, 25, 50, 64, 64, 128, 0, 26);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
